// File: rtl/capture_sequencer_pkg.sv
// Shared state encoding and timing defaults for the ADC capture sequencer.
// The state values are visible on the debug readback port, so they are fixed.
package capture_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_GAP       = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int ARM_SETTLE_DEF = 4;
  localparam int GAP_MIN_DEF    = 2;

endpackage

// File: rtl/capture_sequencer_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement, stops at zero.
// Zero flag is registered-state based, so it reflects the count one cycle after load.
module cap_seq_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Sequences FIFO arm, trigger qualification and segmented capture-go for the ADC path.
// All outputs registered; go follows a qualified trigger edge by one cycle.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int SEG_W      = 16,
  parameter int TMO_W      = 32,
  parameter int ARM_SETTLE = ARM_SETTLE_DEF,
  parameter int GAP_MIN    = GAP_MIN_DEF
) (
  input  logic             adc_sampleclk,
  input  logic             reset_n_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             trig_i,
  input  logic             stream_mode_i,
  input  logic [SEG_W-1:0] num_segments_i,
  input  logic [15:0]      seg_gap_i,
  input  logic [TMO_W-1:0] timeout_i,
  input  logic             adc_capture_stop_i,
  input  logic             fifo_overflow_i,
  output logic             fifo_arm_o,
  output logic             adc_capture_go_o,
  output logic             adc_capture_armed_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             overflow_err_o,
  output logic [SEG_W-1:0] segments_done_o,
  output logic [2:0]       state_o
);

  localparam int SW1 = SEG_W + 1;

  state_e           state_q;
  logic             arm_q, trig_q;
  logic             fifo_arm_q, go_q, armed_q, busy_q, done_q;
  logic             timeout_q, ovf_q;
  logic [SEG_W-1:0] seg_done_q;

  logic             arm_edge, trig_edge;
  logic [15:0]      gap_eff;
  logic [SEG_W-1:0] num_eff, seg_inc;
  logic             last_seg, tmo_fire;
  logic             settle_zero, gap_zero, tmo_zero;

  always_comb begin
    arm_edge  = arm_i & ~arm_q;
    trig_edge = trig_i & ~trig_q;
    gap_eff   = (seg_gap_i < 16'(GAP_MIN)) ? 16'(GAP_MIN) : seg_gap_i;
    num_eff   = (num_segments_i == '0) ? SEG_W'(1) : num_segments_i;
    last_seg  = (SW1'(seg_done_q) + SW1'(1)) >= SW1'(num_eff);
    seg_inc   = (&seg_done_q) ? seg_done_q : seg_done_q + SEG_W'(1);
    tmo_fire  = (timeout_i != '0) && tmo_zero;
  end

  // Counters reload continuously outside their own state, so each entry starts fresh.
  cap_seq_cnt #(.W(16)) u_settle (
    .clk_i      (adc_sampleclk),
    .rst_n_i    (reset_n_i),
    .load_i     (state_q == ST_IDLE),
    .load_val_i (16'(ARM_SETTLE - 1)),
    .dec_i      (state_q == ST_ARM),
    .zero_o     (settle_zero)
  );

  cap_seq_cnt #(.W(16)) u_gap (
    .clk_i      (adc_sampleclk),
    .rst_n_i    (reset_n_i),
    .load_i     (state_q != ST_GAP),
    .load_val_i (gap_eff - 16'(1)),
    .dec_i      (state_q == ST_GAP),
    .zero_o     (gap_zero)
  );

  cap_seq_cnt #(.W(TMO_W)) u_tmo (
    .clk_i      (adc_sampleclk),
    .rst_n_i    (reset_n_i),
    .load_i     (state_q != ST_WAIT_TRIG),
    .load_val_i (timeout_i - TMO_W'(1)),
    .dec_i      (state_q == ST_WAIT_TRIG),
    .zero_o     (tmo_zero)
  );

  always_ff @(posedge adc_sampleclk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      arm_q      <= 1'b0;
      trig_q     <= 1'b0;
      fifo_arm_q <= 1'b0;
      go_q       <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ovf_q      <= 1'b0;
      seg_done_q <= '0;
    end else begin
      arm_q  <= arm_i;
      trig_q <= trig_i;
      case (state_q)
        ST_IDLE: begin
          if (arm_edge) begin
            timeout_q  <= 1'b0;
            ovf_q      <= 1'b0;
            seg_done_q <= '0;
            fifo_arm_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (abort_i) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (settle_zero) begin
            armed_q <= 1'b1;
            state_q <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (abort_i) begin
            armed_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (trig_edge) begin
            armed_q <= 1'b0;
            go_q    <= 1'b1;
            state_q <= ST_CAPTURE;
          end else if (tmo_fire) begin
            armed_q   <= 1'b0;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_CAPTURE: begin
          if (abort_i) begin
            go_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (fifo_overflow_i) begin
            go_q    <= 1'b0;
            ovf_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (!stream_mode_i && adc_capture_stop_i) begin
            go_q       <= 1'b0;
            seg_done_q <= seg_inc;
            if (last_seg) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (abort_i) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (gap_zero) begin
            armed_q <= 1'b1;
            state_q <= ST_WAIT_TRIG;
          end
        end
        ST_DONE: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          fifo_arm_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          go_q       <= 1'b0;
          armed_q    <= 1'b0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          fifo_arm_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_arm_o          = fifo_arm_q;
  assign adc_capture_go_o    = go_q;
  assign adc_capture_armed_o = armed_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign timeout_o           = timeout_q;
  assign overflow_err_o      = ovf_q;
  assign segments_done_o     = seg_done_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: cycle table for short sequences, hand-written
// sequences for settle, segment gaps, timeout, stream overflow and mid-session reset.
module tb_capture_sequencer;

  localparam int SEG_W = 16;
  localparam int TMO_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm_i = 1'b0, abort_i = 1'b0, trig_i = 1'b0, stream_i = 1'b0;
  logic [SEG_W-1:0] num_i = 16'd1;
  logic [15:0]      gap_i = 16'd0;
  logic [TMO_W-1:0] tmo_i = 32'd0;
  logic             stop_i = 1'b0, ovf_i = 1'b0;
  logic             fifo_arm_o, go_o, armed_o, busy_o, done_o, timeout_o, ovf_err_o;
  logic [SEG_W-1:0] seg_done_o;
  logic [2:0]       state_o;

  int n_cmp = 0, n_fail = 0;
  int done_seen = 0, go_rise = 0;
  logic go_prev = 1'b0;

  always #5 clk = ~clk;

  capture_sequencer #(.SEG_W(SEG_W), .TMO_W(TMO_W)) dut (
    .adc_sampleclk       (clk),
    .reset_n_i           (rst_n),
    .arm_i               (arm_i),
    .abort_i             (abort_i),
    .trig_i              (trig_i),
    .stream_mode_i       (stream_i),
    .num_segments_i      (num_i),
    .seg_gap_i           (gap_i),
    .timeout_i           (tmo_i),
    .adc_capture_stop_i  (stop_i),
    .fifo_overflow_i     (ovf_i),
    .fifo_arm_o          (fifo_arm_o),
    .adc_capture_go_o    (go_o),
    .adc_capture_armed_o (armed_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .timeout_o           (timeout_o),
    .overflow_err_o      (ovf_err_o),
    .segments_done_o     (seg_done_o),
    .state_o             (state_o)
  );

  typedef struct {
    logic [3:0] in;   // {arm, abort, trig, stop}
    logic [2:0] st;
    logic [4:0] out;  // {fifo_arm, go, armed, busy, done}
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done_o) done_seen++;
    if (go_o && !go_prev) go_rise++;
    go_prev = go_o;
  endtask

  task automatic start_session();
    arm_i = 1'b0;
    step();
    arm_i = 1'b1;
    step();
    chk("arm_entry_state", 32'(state_o), 1);
    chk("arm_entry_fifo_arm", 32'(fifo_arm_o), 1);
  endtask

  task automatic wait_armed();
    int n = 0;
    while (!armed_o && n < 20) begin
      step();
      n++;
    end
    chk("settle_cycles", n, 4);
  endtask

  task automatic clear_counts();
    done_seen = 0;
    go_rise   = 0;
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 3'd0, 5'b00000};
    tbl[1]  = '{4'b1000, 3'd1, 5'b10010};
    tbl[2]  = '{4'b1000, 3'd1, 5'b10010};
    tbl[3]  = '{4'b1000, 3'd1, 5'b10010};
    tbl[4]  = '{4'b1000, 3'd1, 5'b10010};
    tbl[5]  = '{4'b1000, 3'd2, 5'b10110};
    tbl[6]  = '{4'b1110, 3'd5, 5'b10011};
    tbl[7]  = '{4'b1010, 3'd0, 5'b00000};
    tbl[8]  = '{4'b1000, 3'd0, 5'b00000};
    tbl[9]  = '{4'b0000, 3'd0, 5'b00000};
    tbl[10] = '{4'b1000, 3'd1, 5'b10010};
    tbl[11] = '{4'b1000, 3'd1, 5'b10010};
    tbl[12] = '{4'b1000, 3'd1, 5'b10010};
    tbl[13] = '{4'b1000, 3'd1, 5'b10010};
    tbl[14] = '{4'b1000, 3'd2, 5'b10110};
    tbl[15] = '{4'b1010, 3'd3, 5'b11010};
    tbl[16] = '{4'b1011, 3'd5, 5'b10011};
    tbl[17] = '{4'b1000, 3'd0, 5'b00000};

    // Reset state
    step();
    step();
    chk("reset_outputs", 32'({fifo_arm_o, go_o, armed_o, busy_o, done_o, timeout_o,
                              ovf_err_o, seg_done_o, state_o}), 0);
    #3 rst_n = 1'b1;

    // Cycle table: abort in IDLE, abort beats trigger, held arm ignored, short session
    for (int i = 0; i < 18; i++) begin
      {arm_i, abort_i, trig_i, stop_i} = tbl[i].in;
      step();
      chk($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_outs", i),
          32'({fifo_arm_o, go_o, armed_o, busy_o, done_o}), 32'(tbl[i].out));
      if (i == 16) chk("tbl_seg_done", 32'(seg_done_o), 1);
    end
    {arm_i, abort_i, trig_i, stop_i} = 4'b0000;

    // Single segment: trigger 10 cycles after armed, go held 100 cycles
    begin
      int n;
      num_i = 16'd1;
      clear_counts();
      start_session();
      wait_armed();
      repeat (10) step();
      trig_i = 1'b1;
      step();
      chk("single_go_latency", 32'(go_o), 1);
      n = 0;
      while (go_o && n < 200) begin
        n++;
        if (n == 100) stop_i = 1'b1;
        step();
        stop_i = 1'b0;
      end
      trig_i = 1'b0;
      chk("single_go_cycles", n, 100);
      chk("single_done", 32'(done_o), 1);
      chk("single_seg_done", 32'(seg_done_o), 1);
      step();
      chk("single_idle", 32'({state_o, fifo_arm_o, done_o}), 0);
      chk("single_done_count", done_seen, 1);
    end

    // Segmented: 3 segments, gap clamps to 2, trigger edge inside gap discarded
    begin
      int g;
      num_i = 16'd3;
      gap_i = 16'd0;
      clear_counts();
      start_session();
      wait_armed();
      for (int s = 0; s < 3; s++) begin
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        chk($sformatf("seg%0d_go", s), 32'(go_o), 1);
        repeat (4) step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk($sformatf("seg%0d_count", s), 32'(seg_done_o), s + 1);
        if (s < 2) begin
          g = 0;
          while (state_o == 3'd4 && g < 20) begin
            g++;
            trig_i = (g == 1);
            step();
          end
          trig_i = 1'b0;
          chk($sformatf("seg%0d_gap_len", s), g, 2);
          repeat (3) step();
          chk($sformatf("seg%0d_gap_trig_ignored", s), 32'({state_o, go_o, armed_o}), 32'({3'd2, 1'b0, 1'b1}));
        end
      end
      chk("seg_final_state", 32'(state_o), 5);
      step();
      step();
      chk("seg_go_pulses", go_rise, 3);
      chk("seg_done_count", done_seen, 1);
      chk("seg_done_final", 32'(seg_done_o), 3);
    end

    // Timeout after 50 cycles with no trigger
    begin
      int n;
      num_i = 16'd1;
      tmo_i = 32'd50;
      clear_counts();
      start_session();
      wait_armed();
      n = 0;
      while (!timeout_o && n < 200) begin
        step();
        n++;
      end
      chk("tmo_cycles", n, 50);
      chk("tmo_done", 32'({state_o, done_o}), 32'({3'd5, 1'b1}));
      step();
      chk("tmo_go_never", go_rise, 0);
      chk("tmo_sticky", 32'(timeout_o), 1);

      // Trigger edge on the final counting cycle wins over timeout
      start_session();
      chk("tmo_cleared_on_arm", 32'(timeout_o), 0);
      wait_armed();
      repeat (49) step();
      trig_i = 1'b1;
      step();
      trig_i = 1'b0;
      chk("tmo_trig_wins_state", 32'({state_o, go_o}), 32'({3'd3, 1'b1}));
      chk("tmo_trig_wins_flag", 32'(timeout_o), 0);
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      step();
      chk("tmo_trig_session_end", 32'({state_o, timeout_o}), 0);
      tmo_i = 32'd0;
    end

    // Stream mode: stop ignored, overflow ends the session
    begin
      int n;
      stream_i = 1'b1;
      clear_counts();
      start_session();
      wait_armed();
      trig_i = 1'b1;
      step();
      trig_i = 1'b0;
      n = 0;
      for (int c = 0; c < 1000; c++) begin
        stop_i = (c == 10 || c == 500);
        if (go_o) n++;
        step();
      end
      stop_i = 1'b0;
      chk("stream_go_held", n, 1000);
      chk("stream_state", 32'(state_o), 3);
      ovf_i = 1'b1;
      step();
      ovf_i = 1'b0;
      chk("stream_ovf_go_drop", 32'({go_o, done_o, ovf_err_o}), 32'(3'b011));
      step();
      chk("stream_ovf_sticky", 32'({state_o, ovf_err_o}), 32'({3'd0, 1'b1}));
      chk("stream_seg_done", 32'(seg_done_o), 0);
      stream_i = 1'b0;
    end

    // Reset mid-capture
    start_session();
    chk("ovf_cleared_on_arm", 32'(ovf_err_o), 0);
    wait_armed();
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    chk("pre_reset_capture", 32'(state_o), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({fifo_arm_o, go_o, armed_o, busy_o, done_o, timeout_o,
                                    ovf_err_o, seg_done_o, state_o}), 0);
    arm_i = 1'b0;
    step();
    #3 rst_n = 1'b1;
    clear_counts();
    start_session();
    wait_armed();
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("post_reset_session", 32'({state_o, done_o, seg_done_o}), 32'({3'd5, 1'b1, 16'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
